// File: rtl/vpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vpu_pkg
// Purpose  : Opcodes, sizing, sequencer state encoding, reduce legality
// Revision : 1.0 - initial release
// ============================================================================
package vpu_pkg;

  localparam int LANES = 8;
  localparam int LW    = 16;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_MUL  = 5'd2;
  localparam logic [4:0] OP_ITF  = 5'd3;
  localparam logic [4:0] OP_FTI  = 5'd4;
  localparam logic [4:0] OP_FTL  = 5'd5;
  localparam logic [4:0] OP_MAX  = 5'd6;
  localparam logic [4:0] OP_MIN  = 5'd7;
  localparam logic [4:0] OP_AND  = 5'd8;
  localparam logic [4:0] OP_OR   = 5'd9;
  localparam logic [4:0] OP_XOR  = 5'd10;
  localparam logic [4:0] OP_SRA  = 5'd11;
  localparam logic [4:0] OP_SRL  = 5'd12;
  localparam logic [4:0] OP_SLL  = 5'd13;
  localparam logic [4:0] OP_CGE  = 5'd14;
  localparam logic [4:0] OP_CLT  = 5'd15;
  localparam logic [4:0] OP_CEQ  = 5'd16;
  localparam logic [4:0] OP_CNQ  = 5'd17;
  localparam logic [4:0] NUM_OPS = 5'd18;

  typedef logic [2:0] state_t;
  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_EXEC = 3'd1;
  localparam state_t S_RED1 = 3'd2;
  localparam state_t S_RED2 = 3'd3;
  localparam state_t S_RED3 = 3'd4;
  localparam state_t S_DONE = 3'd5;

  // Bitwise folds have no float meaning; only ADD/MAX/MIN reduce in float mode.
  function automatic logic red_legal(input logic [4:0] code, input logic flt);
    case (code)
      OP_ADD, OP_MAX, OP_MIN: red_legal = 1'b1;
      OP_AND, OP_OR, OP_XOR:  red_legal = !flt;
      default:                red_legal = 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/vpu_op_decode.sv
`default_nettype none
// ============================================================================
// Module   : vpu_op_decode
// Purpose  : Opcode to one-hot VPU select, with illegal-op detection
// Revision : 1.0 - initial release
// ============================================================================
module vpu_op_decode
  import vpu_pkg::*;
(
  input  logic [4:0]         op_code_i,
  input  logic               op_float_i,
  input  logic               op_reduce_i,
  output logic [NUM_OPS-1:0] sel_o,
  output logic               illegal_o
);

  logic w_illegal;

  always_comb begin
    w_illegal = (op_code_i >= NUM_OPS) ||
                (op_reduce_i && !red_legal(op_code_i, op_float_i));
    sel_o     = '0;
    if (!w_illegal) begin
      sel_o = {{(NUM_OPS-1){1'b0}}, 1'b1} << op_code_i;
    end
    illegal_o = w_illegal;
  end

endmodule
`default_nettype wire

// File: rtl/vpu_issue_seq.sv
`default_nettype none
// ============================================================================
// Module   : vpu_issue_seq
// Purpose  : Issue sequencer for the combinational VPU, incl. 3-pass reductions
// Revision : 1.0 - initial release
// ============================================================================
module vpu_issue_seq
  import vpu_pkg::*;
#(
  parameter int LANES = 8,
  parameter int LW    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  op_valid,
  output logic                  op_ready,
  input  logic [4:0]            op_code,
  input  logic                  op_float,
  input  logic                  op_vec,
  input  logic                  op_reduce,
  input  logic [LANES*LW-1:0]   op_vs1,
  input  logic [LANES*LW-1:0]   op_vs2,
  input  logic [31:0]           op_fs,
  input  logic [31:0]           op_rs,
  input  logic [LANES-1:0]      op_mask,
  input  logic                  op_masken,
  input  logic [4:0]            op_tag,
  output logic [LANES*LW-1:0]   vpu_vs1,
  output logic [LANES*LW-1:0]   vpu_vs2,
  output logic [31:0]           vpu_fs,
  output logic [31:0]           vpu_rs,
  output logic [31:0]           vpu_mask,
  output logic                  vpu_ifsel,
  output logic                  vpu_vec_en,
  output logic [NUM_OPS-1:0]    vpu_sel,
  input  logic [LANES*LW-1:0]   vpu_vd,
  input  logic [31:0]           vpu_rd,
  input  logic [31:0]           vpu_fd,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [LANES*LW-1:0]   res_vd,
  output logic [31:0]           res_rd,
  output logic [31:0]           res_fd,
  output logic [4:0]            res_tag,
  output logic                  res_err
);

  localparam int VW = LANES * LW;

  state_t             state_q, state_d;
  logic [VW-1:0]      vs1_q, vs2_q, res_vd_q;
  logic [31:0]        fs_q, rs_q, mask_q, res_rd_q, res_fd_q;
  logic               ifsel_q, vec_q, ill_q, res_valid_q, res_err_q;
  logic [NUM_OPS-1:0] sel_q;
  logic [4:0]         tag_q, res_tag_q;

  logic               w_accept, w_illegal, w_red_go;
  logic [NUM_OPS-1:0] w_sel;
  state_t             w_start;

  vpu_op_decode u_decode (
    .op_code_i   (op_code),
    .op_float_i  (op_float),
    .op_reduce_i (op_reduce),
    .sel_o       (w_sel),
    .illegal_o   (w_illegal)
  );

  assign w_accept = op_valid && op_ready;
  assign w_red_go = op_reduce && !w_illegal;
  assign w_start  = w_red_go ? S_RED1 : S_EXEC;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (w_accept) state_d = w_start;
      S_EXEC: state_d = S_DONE;
      S_RED1: state_d = S_RED2;
      S_RED2: state_d = S_RED3;
      S_RED3: state_d = S_DONE;
      S_DONE: if (res_ready) state_d = w_accept ? w_start : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    op_ready = !rst && ((state_q == S_IDLE) || ((state_q == S_DONE) && res_ready));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vs1_q       <= '0;
      vs2_q       <= '0;
      fs_q        <= '0;
      rs_q        <= '0;
      mask_q      <= '0;
      ifsel_q     <= 1'b0;
      vec_q       <= 1'b0;
      sel_q       <= '0;
      tag_q       <= '0;
      ill_q       <= 1'b0;
      res_valid_q <= 1'b0;
      res_vd_q    <= '0;
      res_rd_q    <= '0;
      res_fd_q    <= '0;
      res_tag_q   <= '0;
      res_err_q   <= 1'b0;
    end else begin
      // Reduction passes fold the upper half of the live lanes onto the lower half.
      case (state_q)
        S_EXEC: begin
          res_valid_q <= 1'b1;
          res_vd_q    <= ill_q ? '0 : vpu_vd;
          res_rd_q    <= ill_q ? '0 : vpu_rd;
          res_fd_q    <= ill_q ? '0 : vpu_fd;
          res_err_q   <= ill_q;
          res_tag_q   <= tag_q;
        end
        S_RED1: begin
          vs1_q  <= vpu_vd;
          vs2_q  <= vpu_vd >> (VW / 4);
          mask_q <= 32'h0000_0003;
        end
        S_RED2: begin
          vs1_q  <= vpu_vd;
          vs2_q  <= vpu_vd >> (VW / 8);
          mask_q <= 32'h0000_0001;
        end
        S_RED3: begin
          res_valid_q <= 1'b1;
          res_vd_q    <= {{(VW-LW){1'b0}}, vpu_vd[LW-1:0]};
          res_rd_q    <= '0;
          res_fd_q    <= '0;
          res_err_q   <= 1'b0;
          res_tag_q   <= tag_q;
        end
        S_DONE: if (res_ready) res_valid_q <= 1'b0;
        default: ;
      endcase

      if (w_accept) begin
        vs1_q   <= op_vs1;
        vs2_q   <= w_red_go ? (op_vs1 >> (VW / 2)) : op_vs2;
        fs_q    <= op_fs;
        rs_q    <= op_rs;
        ifsel_q <= op_float;
        vec_q   <= op_vec;
        sel_q   <= w_sel;
        tag_q   <= op_tag;
        ill_q   <= w_illegal;
        if (op_reduce) begin
          mask_q <= 32'h0000_000F;
        end else begin
          mask_q <= op_masken ? {24'h0, op_mask} : 32'hFFFF_FFFF;
        end
      end
    end
  end

  assign vpu_vs1    = vs1_q;
  assign vpu_vs2    = vs2_q;
  assign vpu_fs     = fs_q;
  assign vpu_rs     = rs_q;
  assign vpu_mask   = mask_q;
  assign vpu_ifsel  = ifsel_q;
  assign vpu_vec_en = vec_q;
  assign vpu_sel    = sel_q;
  assign res_valid  = res_valid_q;
  assign res_vd     = res_vd_q;
  assign res_rd     = res_rd_q;
  assign res_fd     = res_fd_q;
  assign res_tag    = res_tag_q;
  assign res_err    = res_err_q;

endmodule
`default_nettype wire

// File: tb/tb_vpu_issue_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_vpu_issue_seq
// Purpose  : Scoreboard bench for vpu_issue_seq with a behavioural VPU model
// Revision : 1.0 - initial release
// ============================================================================
module tb_vpu_issue_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         op_valid, op_ready, op_float, op_vec, op_reduce, op_masken;
  logic [4:0]   op_code, op_tag;
  logic [127:0] op_vs1, op_vs2;
  logic [31:0]  op_fs, op_rs;
  logic [7:0]   op_mask;
  logic [127:0] vpu_vs1, vpu_vs2, vpu_vd;
  logic [31:0]  vpu_fs, vpu_rs, vpu_mask, vpu_rd, vpu_fd;
  logic         vpu_ifsel, vpu_vec_en;
  logic [17:0]  vpu_sel;
  logic         res_valid, res_ready, res_err;
  logic [127:0] res_vd;
  logic [31:0]  res_rd, res_fd;
  logic [4:0]   res_tag;

  typedef struct {
    logic [127:0] vd;
    logic [31:0]  rd;
    logic [31:0]  fd;
    logic [4:0]   tag;
    logic         err;
    int           lat;
    int           acc;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_bad   = 0;
  int   cyc     = 0;
  bit   seen    = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vpu_issue_seq #(.LANES(8), .LW(16)) dut (
    .clk(clk), .rst(rst),
    .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
    .op_float(op_float), .op_vec(op_vec), .op_reduce(op_reduce),
    .op_vs1(op_vs1), .op_vs2(op_vs2), .op_fs(op_fs), .op_rs(op_rs),
    .op_mask(op_mask), .op_masken(op_masken), .op_tag(op_tag),
    .vpu_vs1(vpu_vs1), .vpu_vs2(vpu_vs2), .vpu_fs(vpu_fs), .vpu_rs(vpu_rs),
    .vpu_mask(vpu_mask), .vpu_ifsel(vpu_ifsel), .vpu_vec_en(vpu_vec_en),
    .vpu_sel(vpu_sel), .vpu_vd(vpu_vd), .vpu_rd(vpu_rd), .vpu_fd(vpu_fd),
    .res_valid(res_valid), .res_ready(res_ready), .res_vd(res_vd),
    .res_rd(res_rd), .res_fd(res_fd), .res_tag(res_tag), .res_err(res_err)
  );

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] lane_op(input logic [4:0] code, input logic [15:0] a, input logic [15:0] b);
    case (code)
      5'd0:    return a + b;
      5'd1:    return a - b;
      5'd6:    return (a > b) ? a : b;
      5'd7:    return (a < b) ? a : b;
      5'd8:    return a & b;
      5'd9:    return a | b;
      5'd10:   return a ^ b;
      default: return a;
    endcase
  endfunction

  // Behavioural VPU; deliberately returns junk when no select line is set.
  function automatic logic [127:0] vpu_vd_model(input logic [17:0] sel, input logic [127:0] a,
                                                input logic [127:0] b, input logic [31:0] m);
    logic [4:0]   code;
    logic [127:0] r;
    if (sel == '0) return a;
    code = '0;
    for (int k = 0; k < 18; k++) if (sel[k]) code = 5'(k);
    r = '0;
    for (int i = 0; i < 8; i++)
      if (m[i]) r[i*16 +: 16] = lane_op(code, a[i*16 +: 16], b[i*16 +: 16]);
    return r;
  endfunction

  function automatic logic [31:0] vpu_rd_model(input logic [17:0] sel, input logic [127:0] a,
                                               input logic [127:0] b, input logic [31:0] m);
    logic [31:0] r;
    if (sel == '0) return 32'hDEAD_BEEF;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (m[i] && sel[16]) r[i] = (a[i*16 +: 16] == b[i*16 +: 16]);
      if (m[i] && sel[17]) r[i] = (a[i*16 +: 16] != b[i*16 +: 16]);
    end
    return r;
  endfunction

  assign vpu_vd = vpu_vd_model(vpu_sel, vpu_vs1, vpu_vs2, vpu_mask);
  assign vpu_rd = vpu_rd_model(vpu_sel, vpu_vs1, vpu_vs2, vpu_mask);
  assign vpu_fd = (vpu_sel == '0) ? 32'hF00D_F00D : (vpu_vs1[31:0] ^ vpu_vs2[31:0]);

  function automatic logic [127:0] ramp(input int base);
    logic [127:0] r;
    for (int i = 0; i < 8; i++) r[i*16 +: 16] = 16'(base + i);
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Drive one op, wait for acceptance and queue the expected result.
  task automatic send_op(input logic [4:0] code, input logic flt, input logic red,
                         input logic [127:0] a, input logic [127:0] b,
                         input logic men, input logic [7:0] m, input logic [4:0] tag);
    exp_t        e;
    logic        ill, ok;
    logic [7:0]  lm;
    logic [15:0] acc;
    ill = (code >= 5'd18) ||
          (red && !((code == 5'd0) || (code == 5'd6) || (code == 5'd7) ||
                    (!flt && ((code == 5'd8) || (code == 5'd9) || (code == 5'd10)))));
    e.tag = tag; e.err = ill; e.vd = '0; e.rd = '0; e.fd = '0;
    if (ill) begin
      e.lat = 1;
    end else if (red) begin
      acc = a[15:0];
      for (int i = 1; i < 8; i++) acc = lane_op(code, acc, a[i*16 +: 16]);
      e.vd = {112'h0, acc};
      e.lat = 3;
    end else begin
      lm = men ? m : 8'hFF;
      for (int i = 0; i < 8; i++) begin
        if (lm[i]) e.vd[i*16 +: 16] = lane_op(code, a[i*16 +: 16], b[i*16 +: 16]);
        if (lm[i] && code == 5'd16) e.rd[i] = (a[i*16 +: 16] == b[i*16 +: 16]);
        if (lm[i] && code == 5'd17) e.rd[i] = (a[i*16 +: 16] != b[i*16 +: 16]);
      end
      e.fd = a[31:0] ^ b[31:0];
      e.lat = 1;
    end
    op_code = code; op_float = flt; op_reduce = red; op_vs1 = a; op_vs2 = b;
    op_masken = men; op_mask = m; op_tag = tag; op_fs = $urandom; op_rs = $urandom;
    op_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      ok = op_ready;
    end
    if (!ok) begin
      check_val("accept_timeout", 0, 1);
      op_valid = 1'b0;
      return;
    end
    e.acc = cyc + 1;
    sb.push_back(e);
    @(posedge clk);
    #1 op_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 200 && sb.size() != 0; t++) @(negedge clk);
    if (sb.size() != 0) check_val("drain_timeout", 128'(sb.size()), 0);
    @(posedge clk);
    #1;
  endtask

  // Result monitor: every cycle the buffer is full it must match the queue head.
  initial begin
    forever begin
      @(negedge clk);
      if (res_valid) begin
        if (sb.size() == 0) begin
          check_val("unexpected_result", 1, 0);
        end else begin
          if (!seen) begin
            seen = 1'b1;
            check_val("latency", 128'(cyc - sb[0].acc), 128'(sb[0].lat));
          end
          check_val("res_vd",  res_vd,  sb[0].vd);
          check_val("res_rd",  res_rd,  sb[0].rd);
          check_val("res_fd",  res_fd,  sb[0].fd);
          check_val("res_tag", res_tag, sb[0].tag);
          check_val("res_err", res_err, sb[0].err);
          if (!res_ready) check_val("bp_op_ready", op_ready, 0);
          if (res_ready) begin
            void'(sb.pop_front());
            seen = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] a, b;
    logic [4:0]   rc;
    logic [4:0]   red_ops [7];
    red_ops = '{5'd0, 5'd1, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10};

    rst = 1'b1; op_valid = 1'b0; res_ready = 1'b1; op_code = '0; op_float = 1'b0;
    op_vec = 1'b1; op_reduce = 1'b0; op_vs1 = '0; op_vs2 = '0; op_fs = '0; op_rs = '0;
    op_mask = '0; op_masken = 1'b0; op_tag = '0;

    repeat (3) @(posedge clk);
    #1;
    check_val("rst_op_ready", op_ready, 0);
    check_val("rst_res_valid", res_valid, 0);
    check_val("rst_vpu_sel", vpu_sel, 0);
    rst = 1'b0;
    @(negedge clk);
    check_val("idle_op_ready", op_ready, 1);
    check_val("rst_res_err", res_err, 0);
    check_val("rst_vpu_mask", vpu_mask, 0);
    @(posedge clk);
    #1;

    // Integer ADD, unmasked
    send_op(5'd0, 1'b0, 1'b0, ramp(1), {8{16'h0001}}, 1'b0, 8'h00, 5'd3);
    @(negedge clk);
    check_val("add_sel", vpu_sel, 18'h00001);
    check_val("add_mask", vpu_mask, 32'hFFFF_FFFF);
    check_val("add_vec_en", vpu_vec_en, 1);
    drain();

    // Integer reduce ADD: mask sequence and constant select across passes
    send_op(5'd0, 1'b0, 1'b1, ramp(1), '0, 1'b1, 8'hAA, 5'd4);
    @(negedge clk); check_val("red_mask1", vpu_mask, 32'h0F); check_val("red_sel1", vpu_sel, 18'h1);
    @(negedge clk); check_val("red_mask2", vpu_mask, 32'h03); check_val("red_sel2", vpu_sel, 18'h1);
    @(negedge clk); check_val("red_mask3", vpu_mask, 32'h01); check_val("red_ifsel", vpu_ifsel, 0);
    drain();

    // CEQ with equality in lanes 0 and 2 only, then a masked SUB
    a = ramp(1); b = a;
    for (int i = 0; i < 8; i++) if (i != 0 && i != 2) b[i*16 +: 16] ^= 16'h0100;
    send_op(5'd16, 1'b0, 1'b0, a, b, 1'b0, 8'h00, 5'd5);
    drain();
    send_op(5'd1, 1'b0, 1'b0, ramp(40), ramp(2), 1'b1, 8'h0F, 5'd6);
    @(negedge clk);
    check_val("sub_mask", vpu_mask, 32'h0000_000F);
    drain();

    // Backpressure: result held 4 cycles while the next op waits
    res_ready = 1'b0;
    send_op(5'd0, 1'b0, 1'b0, rnd128(), rnd128(), 1'b0, 8'h00, 5'd7);
    fork
      send_op(5'd6, 1'b0, 1'b0, rnd128(), rnd128(), 1'b0, 8'h00, 5'd8);
      begin
        repeat (5) @(posedge clk);
        #1 res_ready = 1'b1;
      end
    join
    drain();

    // Reset during RED2 discards the op
    send_op(5'd0, 1'b0, 1'b1, ramp(1), '0, 1'b0, 8'h00, 5'd9);
    @(posedge clk);
    #1 rst = 1'b1;
    void'(sb.pop_back());
    @(posedge clk);
    #1;
    check_val("rstmid_res_valid", res_valid, 0);
    check_val("rstmid_vpu_sel", vpu_sel, 0);
    check_val("rstmid_op_ready", op_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    check_val("rstmid_ready_after", op_ready, 1);
    repeat (5) @(posedge clk);
    #1;

    // Illegal ops: out-of-range code, reduce SUB, float reduce AND
    send_op(5'd20, 1'b0, 1'b0, rnd128(), rnd128(), 1'b0, 8'h00, 5'd10);
    @(negedge clk);
    check_val("ill_sel", vpu_sel, 0);
    drain();
    send_op(5'd1, 1'b0, 1'b1, rnd128(), rnd128(), 1'b0, 8'h00, 5'd11);
    @(negedge clk);
    check_val("ill_red_sel", vpu_sel, 0);
    drain();
    send_op(5'd8, 1'b1, 1'b1, rnd128(), rnd128(), 1'b0, 8'h00, 5'd12);
    drain();

    // Back-to-back random traffic
    for (int n = 0; n < 10; n++) begin
      rc = red_ops[$urandom_range(0, 6)];
      send_op(rc, 1'b0, 1'($urandom_range(0, 1)), rnd128(), rnd128(),
              1'($urandom_range(0, 1)), 8'($urandom), 5'(n + 13));
    end
    drain();
    check_val("sb_empty", 128'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vpu_issue_seq.md
Name: vpu_issue_seq

Overview:
- Issue-side sequencer that drives the vector processing unit's operand and operation-select interface.
- Accepts one decoded vector op through a valid/ready handshake and registers its operands.
- Drives the one-hot select lines and the lane mask for the combinational VPU, then captures vd/rd/fd into a result buffer with its own valid/ready handshake.
- Also sequences multi-pass horizontal reductions (sum/max/min/and/or/xor across 8 lanes) in three VPU passes.

Parameters:
- LANES, 8, number of 16-bit lanes (fixed 8; other values unsupported).
- LW, 16, lane width in bits.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- op_valid  in  1  decoded op available
- op_ready  out  1  sequencer can accept op
- op_code  in  5  operation; encoding in vpu_pkg
- op_float  in  1  float (1) / integer (0) function select
- op_vec  in  1  vector-mode enable forwarded to the VPU
- op_reduce  in  1  horizontal reduction request
- op_vs1, op_vs2  in  128  vector operands
- op_fs, op_rs  in  32  scalar float / integer operand
- op_mask  in  8  lane mask register
- op_masken  in  1  mask enable
- op_tag  in  5  destination register tag
- vpu_vs1, vpu_vs2  out  128  registered operands to the VPU
- vpu_fs, vpu_rs  out  32  registered scalars to the VPU
- vpu_mask  out  32  lane mask to the VPU
- vpu_ifsel, vpu_vec_en  out  1  function / vector select
- vpu_sel  out  18  one-hot op select, bit index = opcode
- vpu_vd  in  128  VPU vector result
- vpu_rd  in  32  VPU integer result
- vpu_fd  in  32  VPU float result
- res_valid  out  1  result buffer full
- res_ready  in  1  writeback accepts result
- res_vd  out  128  captured vector result
- res_rd, res_fd  out  32  captured scalar results
- res_tag  out  5  captured destination tag
- res_err  out  1  illegal opcode or illegal reduction

Behaviour:
- Reset (rst sampled high at clk edge):
  - State goes to IDLE; every registered output resets to 0, including res_valid, res_err and vpu_sel.
  - op_ready is forced to 0 while rst is high.
  - An in-flight op or held result is discarded; no result is produced for it.
- States: IDLE, EXEC, RED1, RED2, RED3, DONE.
- op_ready = (state==IDLE) | (state==DONE & res_ready).
- Accept when op_valid & op_ready. On accept:
  - Register operands and tag.
  - Set vpu_mask = op_masken ? {24'h0,op_mask} : 32'hFFFF_FFFF.
  - Decode vpu_sel.
- Non-reduce op: accept -> EXEC.
  - During EXEC the VPU sees the registered operands.
  - At the end-of-EXEC edge, capture vd/rd/fd into res_* and go to DONE.
  - res_valid rises exactly one cycle after the accept edge.
- Reduce op: legal codes are ADD, MAX, MIN, AND, OR, XOR (float allowed only for ADD, MAX, MIN). Flow is accept -> RED1 -> RED2 -> RED3 -> DONE.
  - op_mask is ignored.
  - RED1: vs1 = A, vs2 = A >> 64, mask = 0x0F.
  - RED2: vs1 = vd_prev, vs2 = vd_prev >> 32, mask = 0x03.
  - RED3: vs1 = vd_prev, vs2 = vd_prev >> 16, mask = 0x01.
  - Each pass's vd is registered internally and feeds the next pass.
  - res_vd = {112'h0, vd[15:0]} from RED3; res_rd and res_fd are 0.
  - res_valid rises three cycles after accept.
- DONE: res_* are held stable while res_valid & !res_ready.
  - On res_ready with no new accept: go to IDLE and clear res_valid.
  - On res_ready with a simultaneous accept: go straight to EXEC or RED1 and clear res_valid the same edge. Peak throughput is one op per 2 cycles.
- Illegal op: op_code >= 18, or an illegal reduce combination.
  - vpu_sel = 0, one cycle in EXEC, then DONE with res_err = 1.
  - res_vd, res_rd and res_fd are all 0.
- vpu_sel and vpu_ifsel are held constant for the whole op, including all reduce passes.

Decomposition:
- vpu_pkg:
  - opcode constants: ADD=0, SUB=1, MUL=2, ITF=3, FTI=4, FTL=5, MAX=6, MIN=7, AND=8, OR=9, XOR=10, SRA=11, SRL=12, SLL=13, CGE=14, CLT=15, CEQ=16, CNQ=17, NUM_OPS=18
  - LANES, LW
  - state encoding
  - reduce-legality function
- One sub-module, vpu_op_decode: combinational opcode/float/reduce -> vpu_sel one-hot plus illegal flag.

Test Plan:
- Integer ADD, vs1 lanes 1..8, vs2 all 0x0001, masken=0 -> vpu_sel=bit0; res_valid one cycle after accept; res_vd lanes 0x0002..0x0009.
- Integer reduce ADD, lanes 1..8 -> vpu_mask sequence 0x0F, 0x03, 0x01; res_valid three cycles after accept; res_vd = 0x0024 in lane 0, rest zero.
- CEQ, integer, vs1==vs2 in lanes 0 and 2 only -> res_rd = 32'h0000_0005.
- Backpressure: res_ready low 4 cycles with op_valid held high -> res_* stable, op_ready low. Then res_ready high -> next op accepted that edge, res_valid low one cycle, then high with the new result.
- rst asserted during RED2 -> next cycle state IDLE, res_valid=0, vpu_sel=0, op_ready=1 after rst drops; no result emitted.
- op_code = 5'd20, or reduce SUB -> res_err=1, vpu_sel=0, res_vd=0, res_valid one cycle after accept.
